sbus_dcache: RTL and testbench

//  Direct-mapped, write-through, one-word-line data cache with no write-allocate.

---
 rtl/sbus_dcache.sv | 173 +++++++++++++++++
 tb/tb_sbus_dcache.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sbus_dcache.sv
// rtl/sbus_dcache.sv - direct-mapped write-through data cache between the sbus memory stage and the memory bridge
//
// Purpose: one-word lines, no write-allocate. Load hits in IDLE complete in
// zero cycles; misses, uncached loads and every store go to memory and stall
// the pipeline until the downstream request completes.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   up_en/up_we/up_size        upstream request valid, store flag, access size
//   up_addr/up_data_w          upstream byte address and lane-placed store data
//   up_data_r/up_stall         upstream aligned read word, request-not-complete
//   mem_en/mem_we/mem_size     downstream request valid, store flag, size
//   mem_addr/mem_data_w        downstream address and store data
//   mem_data_r/mem_stall       downstream read data, request-not-complete

module sbus_dcache #(
  parameter int          DEPTH   = 512,
  parameter logic [2:0]  UNC_SEG = 3'b101
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        up_en,
  input  logic        up_we,
  input  logic [1:0]  up_size,
  input  logic [31:0] up_addr,
  input  logic [31:0] up_data_w,
  output logic [31:0] up_data_r,
  output logic        up_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_w,
  input  logic [31:0] mem_data_r,
  input  logic        mem_stall
);

  localparam int IW = $clog2(DEPTH);
  localparam int TW = 32 - IW - 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_MISS = 2'd1,
    S_RD_UNC  = 2'd2,
    S_WRITE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DEPTH-1:0] valid_q;
  logic [TW-1:0]    tag_mem  [DEPTH];
  logic [31:0]      data_mem [DEPTH];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [31:0]   line_data;
  logic [31:0]   merged;
  logic [3:0]    be;
  logic          unc;
  logic          hit;
  logic          load_hit;
  logic          active;
  logic          completing;
  logic          fill;
  logic          wr_hit;

  assign idx       = up_addr[IW+1:2];
  assign tag       = up_addr[31:IW+2];
  assign line_data = data_mem[idx];
  assign unc       = (up_addr[31:29] == UNC_SEG);
  assign hit       = valid_q[idx] && (tag_mem[idx] == tag) && !unc;

  assign load_hit   = (state_q == S_IDLE) && up_en && !up_we && hit;
  assign active     = (state_q != S_IDLE);
  // mem_en is 1 in every non-IDLE state, so completion is just !mem_stall there.
  assign completing = active && !mem_stall;
  assign fill       = (state_q == S_RD_MISS) && completing;
  assign wr_hit     = (state_q == S_WRITE) && completing && hit;

  always_comb begin
    be = 4'b0000;
    case (up_size)
      2'd0:    be = 4'b0001 << up_addr[1:0];
      2'd1:    be = up_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    merged = line_data;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = up_data_w[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (up_en) begin
          if (up_we)     state_d = S_WRITE;
          else if (unc)  state_d = S_RD_UNC;
          else if (!hit) state_d = S_RD_MISS;
        end
      end
      default: begin
        if (!mem_stall) state_d = S_IDLE;
      end
    endcase
  end

  // Downstream request is derived from the state register and the held
  // upstream request, so it is stable for the whole life of a state and
  // collapses to zero the instant reset forces IDLE.
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_size   = 2'd0;
    mem_addr   = 32'h0;
    mem_data_w = 32'h0;
    case (state_q)
      S_RD_MISS, S_RD_UNC: begin
        mem_en   = 1'b1;
        mem_size = 2'd2;
        mem_addr = {up_addr[31:2], 2'b00};
      end
      S_WRITE: begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        mem_size   = up_size;
        mem_addr   = up_addr;
        mem_data_w = up_data_w;
      end
      default: ;
    endcase
  end

  always_comb begin
    up_data_r = 32'h0;
    if (load_hit) begin
      up_data_r = line_data;
    end else if (completing && (state_q != S_WRITE)) begin
      up_data_r = mem_data_r;
    end
  end

  assign up_stall = up_en && !load_hit && !completing;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless while the valid bit is clear, so
  // these arrays carry no reset.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= mem_data_r;
    end else if (wr_hit) begin
      data_mem[idx] <= merged;
    end
  end

endmodule

// File: tb/tb_sbus_dcache.sv
// tb/tb_sbus_dcache.sv - self-checking bench for sbus_dcache

module tb_sbus_dcache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        up_en, up_we;
  logic [1:0]  up_size;
  logic [31:0] up_addr, up_data_w, up_data_r;
  logic        up_stall;
  logic        mem_en, mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_data_w, mem_data_r;
  logic        mem_stall;

  sbus_dcache dut (
    .clk(clk), .rst_n(rst_n),
    .up_en(up_en), .up_we(up_we), .up_size(up_size), .up_addr(up_addr),
    .up_data_w(up_data_w), .up_data_r(up_data_r), .up_stall(up_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_data_w(mem_data_w), .mem_data_r(mem_data_r), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected outputs for the current cycle, set by the driver.
  logic        check_en = 1'b0;
  logic        exp_stall, exp_mem_en, exp_mem_we;
  logic [1:0]  exp_mem_size;
  logic [31:0] exp_mem_addr, exp_mem_data_w, exp_data_r;

  // Cache model: per index, which word address (addr[31:2]) it holds and its data.
  logic [29:0] m_line [int];
  logic [31:0] m_data [int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_idx(input logic [31:0] a);
    return int'(a[10:2]);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    if (a[31:29] == 3'b101) return 1'b0;
    return m_line.exists(m_idx(a)) && (m_line[m_idx(a)] == a[31:2]);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    return m_data[m_idx(a)];
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("up_stall", {31'b0, up_stall}, {31'b0, exp_stall});
      chk("mem_en", {31'b0, mem_en}, {31'b0, exp_mem_en});
      chk("up_data_r", up_data_r, exp_data_r);
      if (exp_mem_en) begin
        chk("mem_we", {31'b0, mem_we}, {31'b0, exp_mem_we});
        chk("mem_size", {30'b0, mem_size}, {30'b0, exp_mem_size});
        chk("mem_addr", mem_addr, exp_mem_addr);
        if (exp_mem_we) chk("mem_data_w", mem_data_w, exp_mem_data_w);
      end
    end
  end

  task automatic set_idle();
    up_en = 1'b0; up_we = 1'b0; up_size = 2'd0; up_addr = 32'h0; up_data_w = 32'h0;
    mem_stall = 1'b0; mem_data_r = 32'h0;
    exp_stall = 1'b0; exp_mem_en = 1'b0; exp_mem_we = 1'b0; exp_mem_size = 2'd0;
    exp_mem_addr = 32'h0; exp_mem_data_w = 32'h0; exp_data_r = 32'h0;
  endtask

  task automatic idle(input int n);
    set_idle();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // One upstream request; memory answers rd after nstall stalled cycles.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int nstall,
                        output int stall_cnt, output int mem_cnt);
    bit hit, needs, unc;
    int total;
    logic [31:0] d;
    int lo;
    unc   = (a[31:29] == 3'b101);
    hit   = m_hit(a);
    needs = we || !hit;
    total = needs ? nstall + 2 : 1;
    stall_cnt = 0;
    mem_cnt = 0;
    up_en = 1'b1; up_we = we; up_size = sz; up_addr = a; up_data_w = wd;
    mem_data_r = rd;
    for (int c = 0; c < total; c++) begin
      mem_stall      = needs && (c >= 1) && (c - 1 < nstall);
      exp_stall      = (c < total - 1);
      exp_mem_en     = needs && (c >= 1);
      exp_mem_we     = we;
      exp_mem_size   = we ? sz : 2'd2;
      exp_mem_addr   = we ? a : {a[31:2], 2'b00};
      exp_mem_data_w = wd;
      if (c == total - 1 && !we) exp_data_r = needs ? rd : m_read(a);
      else                       exp_data_r = 32'h0;
      check_en = 1'b1;
      @(negedge clk);
      if (up_stall) stall_cnt++;
      if (mem_en) mem_cnt++;
      @(posedge clk); #1;
    end
    set_idle();
    if (!we && !unc && !hit) begin
      m_line[m_idx(a)] = a[31:2];
      m_data[m_idx(a)] = rd;
    end else if (we && hit) begin
      d  = m_read(a);
      lo = int'(a[1:0]);
      for (int b = lo; b < lo + (1 << sz); b++) d[8*b +: 8] = wd[8*b +: 8];
      m_data[m_idx(a)] = d;
    end
  endtask

  int sc, mc;

  initial begin
    set_idle();
    rst_n = 1'b0;
    #12;
    chk("reset_mem_en", {31'b0, mem_en}, 32'h0);
    chk("reset_mem_we", {31'b0, mem_we}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_data_r", up_data_r, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(2);

    // Cold miss with three stalled memory cycles.
    do_req(1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 3, sc, mc);
    chk("miss_stall_cycles", sc, 4);
    chk("miss_mem_cycles", mc, 4);
    do_req(1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'h0, 0, sc, mc);
    chk("hit_stall_cycles", sc, 0);
    chk("hit_mem_cycles", mc, 0);

    // Byte store hit, then the merged word is read back next cycle.
    do_req(1'b1, 2'd0, 32'h8000_0011, 32'h0000_AA00, 32'h0, 1, sc, mc);
    chk("model_byte_merge", m_read(32'h8000_0010), 32'hDEAD_AAEF);
    do_req(1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'h0, 0, sc, mc);

    // Uncached loads always go to memory and never fill; 1-cycle latency.
    do_req(1'b0, 2'd2, 32'hA000_0010, 32'h0, 32'h1234_5678, 0, sc, mc);
    chk("unc_stall_cycles", sc, 1);
    do_req(1'b0, 2'd2, 32'hA000_0010, 32'h0, 32'h1234_5678, 0, sc, mc);
    chk("unc2_mem_cycles", mc, 1);
    do_req(1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'h0, 0, sc, mc);
    chk("cached_after_unc", sc, 0);

    // Same index, new tag: eviction, then original address misses.
    do_req(1'b0, 2'd2, 32'h8000_0810, 32'h0, 32'hCAFE_F00D, 0, sc, mc);
    do_req(1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'hDEAD_AAEF, 2, sc, mc);
    chk("evicted_reload_stall", sc, 3);

    // Store miss does not allocate.
    do_req(1'b1, 2'd2, 32'h8000_0020, 32'h1111_2222, 32'h0, 0, sc, mc);
    do_req(1'b0, 2'd2, 32'h8000_0020, 32'h0, 32'h3333_4444, 1, sc, mc);
    chk("no_alloc_mem_cycles", mc, 2);

    // Half store hit on the upper half, uncached store, then read back.
    do_req(1'b1, 2'd1, 32'h8000_0012, 32'h5566_0000, 32'h0, 0, sc, mc);
    chk("model_half_merge", m_read(32'h8000_0010), 32'h5566_AAEF);
    do_req(1'b1, 2'd2, 32'hA000_0010, 32'h7777_8888, 32'h0, 0, sc, mc);
    do_req(1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'h0, 0, sc, mc);
    idle(1);

    // Reset in the middle of a stalled refill.
    check_en = 1'b0;
    up_en = 1'b1; up_we = 1'b0; up_size = 2'd2; up_addr = 32'h8000_0410;
    mem_stall = 1'b1; mem_data_r = 32'h9999_9999;
    @(posedge clk); #1;
    chk("pre_reset_mem_en", {31'b0, mem_en}, 32'h1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_mem_en", {31'b0, mem_en}, 32'h0);
    chk("mid_reset_mem_addr", mem_addr, 32'h0);
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    m_line.delete();
    m_data.delete();
    @(posedge clk); #1;
    do_req(1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'h0BAD_F00D, 0, sc, mc);
    chk("post_reset_miss_mem", mc, 1);
    do_req(1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'h0, 0, sc, mc);
    idle(2);
    check_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
